maze_walker: RTL and testbench

- Parametrised player/position engine for grid-maze games.
- Tracks player (x,y) on a configurable grid and senses the four surrounding walls from an external maze-data store over a req/ack query port.
- Accepts one move per button press and latches a win when the goal cell is reached.
- Sits between the debounced button inputs and the display/LED output mapping in the top level.

---
 rtl/maze_pkg.sv | 45 ++++
 rtl/maze_wall_sense.sv | 158 +++++++++++++++
 rtl/maze_walker.sv | 160 ++++++++++++++++
 tb/tb_maze_walker.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
//   Shared types and constants for the maze_walker player/position engine.
//   - state_e      : sensing sequencer + idle/win states
//   - DIR_*        : index of each direction in btn_i and in the walls vector
//                    (btn = {right,left,down,up}, walls = {right,left,bottom,top})
//   - QV_*         : encodings of the q_vert_o query field
//   - next_sense() : successor of a sensing state (S_RIGHT is handled by caller)
// -----------------------------------------------------------------------------
package maze_pkg;

  typedef enum logic [2:0] {
    S_TOP   = 3'd0,
    S_BOT   = 3'd1,
    S_LEFT  = 3'd2,
    S_RIGHT = 3'd3,
    READY   = 3'd4,
    WIN     = 3'd5
  } state_e;

  // The same index addresses a button and the wall blocking that direction.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // q_vert_o: 0 = horizontal edge at top of cell, 1 = vertical edge at left.
  localparam logic QV_HORIZ = 1'b0;
  localparam logic QV_VERT  = 1'b1;

  localparam logic [3:0] WALLS_ALL = 4'b1111;

  function automatic state_e next_sense(input state_e s);
    state_e n;
    n = S_TOP;
    case (s)
      S_TOP:   n = S_BOT;
      S_BOT:   n = S_LEFT;
      S_LEFT:  n = S_RIGHT;
      default: n = S_TOP;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/maze_wall_sense.sv
// -----------------------------------------------------------------------------
// maze_wall_sense
//   Owns the engine state machine: walks the four edges of the current cell
//   (top, bottom, left, right) over the req/ack query port, collects the
//   answers in a shadow register, then publishes all four bits at once.
//   Edges on the grid border are forced to "wall" without issuing a query.
//
//   Query handshake: q_req_o is valid while the sequencer sits in a sensing
//   state on a non-border edge; the address is constant for as long as
//   q_req_o is held. A transfer happens on any cycle with q_req_o && q_ack_i,
//   at which point q_wall_i is captured and the sequencer advances. q_ack_i
//   seen while q_req_o is low has no effect.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   pos_x_i, pos_y_i    current player cell (stable while sensing)
//   start_i             accepted move in READY: restart sensing
//   goal_i              current cell is the goal (used when sensing ends)
//   q_ack_i, q_wall_i   query response
//   q_req_o, q_x_o,
//   q_y_o, q_vert_o     query request and edge address
//   walls_o             {right,left,bottom,top}, 1 = blocked
//   state_o             current state (debug / ready+win decode)
// -----------------------------------------------------------------------------
module maze_wall_sense
  import maze_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int MAX_X   = 15,
  parameter int MAX_Y   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] pos_x_i,
  input  logic [COORD_W-1:0] pos_y_i,
  input  logic               start_i,
  input  logic               goal_i,
  input  logic               q_ack_i,
  input  logic               q_wall_i,
  output logic               q_req_o,
  output logic [COORD_W-1:0] q_x_o,
  output logic [COORD_W-1:0] q_y_o,
  output logic               q_vert_o,
  output logic [3:0]         walls_o,
  output state_e             state_o
);

  localparam logic [COORD_W-1:0] MAX_X_C = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] MAX_Y_C = COORD_W'(MAX_Y);

  state_e     state_q, state_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] walls_q, walls_d;

  logic       at_top, at_bot, at_left, at_right;
  logic       sensing, forced, adv, bit_val;
  logic [1:0] bit_idx;

  assign at_top   = (pos_y_i == '0);
  assign at_bot   = (pos_y_i == MAX_Y_C);
  assign at_left  = (pos_x_i == '0);
  assign at_right = (pos_x_i == MAX_X_C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_TOP;
      shadow_q <= '0;
      walls_q  <= WALLS_ALL;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      walls_q  <= walls_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    walls_d  = walls_q;
    q_req_o  = 1'b0;
    q_x_o    = pos_x_i;
    q_y_o    = pos_y_i;
    q_vert_o = QV_HORIZ;
    sensing  = 1'b0;
    forced   = 1'b0;
    bit_idx  = DIR_UP;
    adv      = 1'b0;
    bit_val  = 1'b0;

    // Each sensing state names one edge of the cell; the neighbouring cell's
    // top/left edge is used for our bottom/right edge.
    case (state_q)
      S_TOP: begin
        sensing = 1'b1;
        forced  = at_top;
        bit_idx = DIR_UP;
      end
      S_BOT: begin
        sensing = 1'b1;
        forced  = at_bot;
        bit_idx = DIR_DOWN;
        q_y_o   = pos_y_i + 1'b1;
      end
      S_LEFT: begin
        sensing  = 1'b1;
        forced   = at_left;
        bit_idx  = DIR_LEFT;
        q_vert_o = QV_VERT;
      end
      S_RIGHT: begin
        sensing  = 1'b1;
        forced   = at_right;
        bit_idx  = DIR_RIGHT;
        q_x_o    = pos_x_i + 1'b1;
        q_vert_o = QV_VERT;
      end
      READY: begin
        if (start_i) begin
          walls_d = WALLS_ALL;
          state_d = S_TOP;
        end
      end
      WIN: begin
        // Terminal until reset.
      end
      default: state_d = S_TOP;
    endcase

    // Border edges never leave the grid, so they are walls by construction
    // and cost one cycle without touching the query port.
    if (sensing) begin
      if (forced) begin
        adv     = 1'b1;
        bit_val = 1'b1;
      end else begin
        q_req_o = 1'b1;
        adv     = q_ack_i;
        bit_val = q_wall_i;
      end
    end

    if (adv) begin
      shadow_d[bit_idx] = bit_val;
      if (state_q == S_RIGHT) begin
        // Publish all four edges together so the move logic never sees a
        // half-updated wall set.
        walls_d = shadow_d;
        state_d = goal_i ? WIN : READY;
      end else begin
        state_d = next_sense(state_q);
      end
    end
  end

  assign walls_o = walls_q;
  assign state_o = state_q;

endmodule

// File: rtl/maze_walker.sv
// -----------------------------------------------------------------------------
// maze_walker
//   Player/position engine for grid-maze games. Holds the player cell, takes
//   one move per button press (priority up > down > left > right, blocked
//   choice is simply ignored), re-senses the surrounding walls after every
//   move through maze_wall_sense, and latches a win on the goal cell.
//
//   Optional build macro: MAZE_MOVE_COUNT_EN adds the moves_o port and a
//   saturating accepted-move counter. Without it the port and counter are
//   absent and everything else is unchanged.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   btn_i[3:0]          {right,left,down,up}, debounced levels
//   q_req_o, q_x_o,
//   q_y_o, q_vert_o     wall query request/address (see maze_wall_sense)
//   q_ack_i, q_wall_i   wall query response
//   pos_x_o, pos_y_o    current cell
//   walls_o[3:0]        {right,left,bottom,top}, 1 = blocked
//   ready_o             accepting moves
//   win_o               goal reached (held until reset)
//   moves_o             accepted-move count (MAZE_MOVE_COUNT_EN only)
// -----------------------------------------------------------------------------
module maze_walker
  import maze_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int MAX_X   = 15,
  parameter int MAX_Y   = 15,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 9,
  parameter int GOAL_Y  = 9,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         btn_i,
  output logic               q_req_o,
  output logic [COORD_W-1:0] q_x_o,
  output logic [COORD_W-1:0] q_y_o,
  output logic               q_vert_o,
  input  logic               q_ack_i,
  input  logic               q_wall_i,
  output logic [COORD_W-1:0] pos_x_o,
  output logic [COORD_W-1:0] pos_y_o,
  output logic [3:0]         walls_o,
  output logic               ready_o,
  output logic               win_o
`ifdef MAZE_MOVE_COUNT_EN
  ,
  output logic [CNT_W-1:0]   moves_o
`endif
);

  localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] GOAL_X_C  = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GOAL_Y_C  = COORD_W'(GOAL_Y);

  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic               held_q;
  logic               press;
  logic [1:0]         dir;
  logic               move_ok;
  logic               goal_hit;
  logic [3:0]         walls;
  state_e             state;

  // A press is the rising edge of "any button down". held_q keeps tracking
  // during sensing, so a button held through a move never fires twice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q  <= 1'b0;
      pos_x_q <= START_X_C;
      pos_y_q <= START_Y_C;
    end else begin
      held_q  <= |btn_i;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  always_comb begin
    press = (|btn_i) && !held_q;

    // Only the highest-priority pressed direction is considered; if it is
    // walled off, lower-priority buttons in the same press are not tried.
    if (btn_i[DIR_UP])        dir = DIR_UP;
    else if (btn_i[DIR_DOWN]) dir = DIR_DOWN;
    else if (btn_i[DIR_LEFT]) dir = DIR_LEFT;
    else                      dir = DIR_RIGHT;

    move_ok = (state == READY) && press && !walls[dir];

    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (move_ok) begin
      case (dir)
        DIR_UP:   pos_y_d = pos_y_q - 1'b1;
        DIR_DOWN: pos_y_d = pos_y_q + 1'b1;
        DIR_LEFT: pos_x_d = pos_x_q - 1'b1;
        default:  pos_x_d = pos_x_q + 1'b1;
      endcase
    end
  end

  assign goal_hit = (pos_x_q == GOAL_X_C) && (pos_y_q == GOAL_Y_C);

  maze_wall_sense #(
    .COORD_W (COORD_W),
    .MAX_X   (MAX_X),
    .MAX_Y   (MAX_Y)
  ) u_sense (
    .clk      (clk),
    .rst_n    (rst_n),
    .pos_x_i  (pos_x_q),
    .pos_y_i  (pos_y_q),
    .start_i  (move_ok),
    .goal_i   (goal_hit),
    .q_ack_i  (q_ack_i),
    .q_wall_i (q_wall_i),
    .q_req_o  (q_req_o),
    .q_x_o    (q_x_o),
    .q_y_o    (q_y_o),
    .q_vert_o (q_vert_o),
    .walls_o  (walls),
    .state_o  (state)
  );

  assign pos_x_o = pos_x_q;
  assign pos_y_o = pos_y_q;
  assign walls_o = walls;
  assign ready_o = (state == READY);
  // WIN is only left through reset, so the state itself is the latch.
  assign win_o   = (state == WIN);

`ifdef MAZE_MOVE_COUNT_EN
  logic [CNT_W-1:0] moves_q, moves_d;

  always_comb begin
    moves_d = moves_q;
    if (move_ok && !(&moves_q)) begin
      moves_d = moves_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      moves_q <= '0;
    end else begin
      moves_q <= moves_d;
    end
  end

  assign moves_o = moves_q;
`endif

endmodule

// File: tb/tb_maze_walker.sv
// -----------------------------------------------------------------------------
// tb_maze_walker
//   Directed bench for maze_walker with a reference model of the player:
//   maze walls live in two arrays, the model moves the player by the button
//   rules and predicts when fresh walls appear from the cost of each edge
//   query (border edge = 1 cycle, queried edge = ack delay + 1 cycles).
// -----------------------------------------------------------------------------
module tb_maze_walker;

  localparam int COORD_W = 4;
  localparam int MAX_X   = 15;
  localparam int MAX_Y   = 15;
  localparam int START_X = 0;
  localparam int START_Y = 0;
  localparam int GOAL_X  = 9;
  localparam int GOAL_Y  = 9;
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0]         btn;
  logic               q_req, q_vert, q_ack, q_wall;
  logic [COORD_W-1:0] q_x, q_y, pos_x, pos_y;
  logic [3:0]         walls;
  logic               ready, win;
`ifdef MAZE_MOVE_COUNT_EN
  logic [CNT_W-1:0]   moves;
`endif

  maze_walker #(
    .COORD_W (COORD_W), .MAX_X (MAX_X), .MAX_Y (MAX_Y),
    .START_X (START_X), .START_Y (START_Y),
    .GOAL_X  (GOAL_X),  .GOAL_Y  (GOAL_Y), .CNT_W (CNT_W)
  ) dut (
`ifdef MAZE_MOVE_COUNT_EN
    .moves_o  (moves),
`endif
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_i    (btn),
    .q_req_o  (q_req),
    .q_x_o    (q_x),
    .q_y_o    (q_y),
    .q_vert_o (q_vert),
    .q_ack_i  (q_ack),
    .q_wall_i (q_wall),
    .pos_x_o  (pos_x),
    .pos_y_o  (pos_y),
    .walls_o  (walls),
    .ready_o  (ready),
    .win_o    (win)
  );

  // ---------------- maze store / responder ----------------
  logic h_wall [0:16][0:16];  // edge at top of (x,y)
  logic v_wall [0:16][0:16];  // edge at left of (x,y)
  int   ack_delay = 0;
  logic ack_force = 1'b0;
  int   wait_cnt  = 0;

  assign q_ack  = ack_force || (q_req && (wait_cnt >= ack_delay));
  assign q_wall = q_vert ? v_wall[q_x][q_y] : h_wall[q_x][q_y];

  always @(posedge clk) begin
    if (q_req && !q_ack) wait_cnt <= wait_cnt + 1;
    else                 wait_cnt <= 0;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_x, m_y, m_left, m_moves, m_dir;
  logic [3:0] m_walls;
  logic       m_held, m_win, m_press;
  logic       m_valid = 1'b0;

  function automatic int edge_cost(input int x, input int y, input int d);
    int c;
    c = 0;
    c += (y == 0)     ? 1 : d + 1;
    c += (y == MAX_Y) ? 1 : d + 1;
    c += (x == 0)     ? 1 : d + 1;
    c += (x == MAX_X) ? 1 : d + 1;
    return c;
  endfunction

  function automatic logic [3:0] true_walls(input int x, input int y);
    logic [3:0] w;
    w[0] = (y == 0)     ? 1'b1 : h_wall[x][y];
    w[1] = (y == MAX_Y) ? 1'b1 : h_wall[x][y+1];
    w[2] = (x == 0)     ? 1'b1 : v_wall[x][y];
    w[3] = (x == MAX_X) ? 1'b1 : v_wall[x+1][y];
    return w;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_x     = START_X;
      m_y     = START_Y;
      m_walls = 4'hF;
      m_win   = 1'b0;
      m_moves = 0;
      m_left  = edge_cost(START_X, START_Y, ack_delay);
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_walls = true_walls(m_x, m_y);
        m_win   = (m_x == GOAL_X) && (m_y == GOAL_Y);
      end
    end else if (!m_win) begin
      m_press = (|btn) && !m_held;
      if (m_press) begin
        m_dir = btn[0] ? 0 : btn[1] ? 1 : btn[2] ? 2 : 3;
        if (!m_walls[m_dir]) begin
          case (m_dir)
            0: m_y = m_y - 1;
            1: m_y = m_y + 1;
            2: m_x = m_x - 1;
            default: m_x = m_x + 1;
          endcase
          m_walls = 4'hF;
          if (m_moves < CNT_MAX) m_moves = m_moves + 1;
          m_left = edge_cost(m_x, m_y, ack_delay);
        end
      end
    end
    m_held  = rst_n && (|btn);
    m_valid = 1'b1;
  end

  // One compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pos_x", pos_x, m_x);
      check("pos_y", pos_y, m_y);
      check("walls", walls, m_walls);
      check("ready", ready, (m_left == 0) && !m_win);
      check("win", win, m_win);
      if (m_left == 0) check("q_req_idle", q_req, 1'b0);
`ifdef MAZE_MOVE_COUNT_EN
      check("moves", moves, m_moves);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!(ready || win) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", ready || win, 1'b1);
  endtask

  task automatic do_move(input logic [3:0] b);
    btn = b;
    @(negedge clk);
    btn = 4'b0000;
    @(negedge clk);
    wait_ready(60);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    btn   = 4'b0000;
    for (int i = 0; i <= 16; i++)
      for (int j = 0; j <= 16; j++) begin
        h_wall[i][j] = 1'b0;
        v_wall[i][j] = 1'b0;
      end
    v_wall[2][0] = 1'b1;  // right edge of (1,0)

    repeat (3) @(negedge clk);
    check("rst_walls", walls, 4'hF);
    check("rst_q_req", q_req, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_pos", {pos_x, pos_y}, 8'h00);
    rst_n = 1'b1;

    // Initial sensing at (0,0): top and left forced, 4 cycles.
    repeat (3) @(negedge clk);
    check("sense_not_ready", ready, 1'b0);
    check("sense_walls_all", walls, 4'hF);
    @(negedge clk);
    check("first_walls", walls, 4'b0101);
    check("first_ready", ready, 1'b1);

    // Right held for 3 cycles: exactly one move.
    btn = 4'b1000;
    repeat (3) @(negedge clk);
    check("one_move_x", pos_x, 4'd1);
`ifdef MAZE_MOVE_COUNT_EN
    check("one_move_cnt", moves, 10'd1);
`endif
    btn = 4'b0000;
    wait_ready(60);
    check("walls_1_0", walls, 4'b1001);

    // Up+right: up wins priority, is blocked, right is not tried.
    btn = 4'b1001;
    repeat (3) @(negedge clk);
    check("blocked_pos", {pos_x, pos_y}, 8'h10);
    check("blocked_walls", walls, 4'b1001);
    check("blocked_ready", ready, 1'b1);
    btn = 4'b0000;
    @(negedge clk);

    // Slow acks: each query waits 3 cycles.
    ack_delay = 3;
    btn = 4'b0010;
    @(negedge clk);
    btn = 4'b0000;
    check("slow_req", q_req, 1'b1);
    check("slow_addr0", {q_x, q_y, 3'b000, q_vert}, {4'd1, 4'd1, 4'b0000});
    @(negedge clk);
    btn = 4'b0100;  // press during sensing, must be ignored
    check("slow_addr1", {q_x, q_y, 3'b000, q_vert}, {4'd1, 4'd1, 4'b0000});
    @(negedge clk);
    btn = 4'b0000;
    check("slow_addr2", {q_x, q_y, 3'b000, q_vert}, {4'd1, 4'd1, 4'b0000});
    check("slow_walls_held", walls, 4'hF);
    n = 2;
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("slow_latency", n, 16);
    check("slow_pos", {pos_x, pos_y}, 8'h11);
    check("slow_walls", walls, 4'b0000);
    ack_delay = 0;

    // Stray ack while idle changes nothing.
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("stray_ack_walls", walls, 4'b0000);

    // Walk (1,1) -> (9,9).
    for (int i = 0; i < 8; i++) do_move(4'b1000);
    for (int i = 0; i < 8; i++) do_move(4'b0010);
    check("win_set", win, 1'b1);
    check("win_ready", ready, 1'b0);
    check("win_pos", {pos_x, pos_y}, 8'h99);
    btn = 4'b0001;
    repeat (3) @(negedge clk);
    btn = 4'b0000;
    check("win_frozen", {pos_x, pos_y}, 8'h99);
    check("win_held", win, 1'b1);
`ifdef MAZE_MOVE_COUNT_EN
    check("win_moves", moves, 10'd18);
`endif

    // Reset clears the win and restores the start cell.
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_win", win, 1'b0);
    check("rst2_pos", {pos_x, pos_y}, 8'h00);
    check("rst2_walls", walls, 4'hF);
    rst_n = 1'b1;
    wait_ready(60);
    check("rst2_sensed", walls, 4'b0101);

`ifdef MAZE_MOVE_COUNT_EN
    // Saturation: 1025 accepted moves from zero.
    for (int i = 0; i < 1025; i++) do_move((i % 2 == 0) ? 4'b1000 : 4'b0100);
    check("moves_sat", moves, 10'h3FF);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
